// File: rtl/regfile_scoreboard.sv
// 32 x XLEN integer register file with a same-cycle write-back bypass, a
// per-register busy scoreboard that interlocks issue against in-flight
// producers, a debug read port, and a count of accepted write-backs.
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue_valid,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall_o,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [XLEN-1:0] a0_o,
  output logic [63:0]     wr_cnt_o
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [63:0]     r_wr_cnt;

  logic            w_wb;
  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_eff_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_rd_nz;

  // A write-back to x0 is counted but never lands in storage or the scoreboard.
  assign w_wb    = we && (waddr != '0);
  assign w_rd_nz = (issue_rd != '0);

  // One-hot mask of the register being written back this cycle.
  always_comb begin
    w_wb_mask = '0;
    if (w_wb) w_wb_mask[waddr] = 1'b1;
  end

  // The current write-back releases its interlock combinationally.
  assign w_eff_busy = r_busy & ~w_wb_mask;

  // Issue is held on RAW hazards for either source or a WAW hazard on rd.
  always_comb begin
    stall_o = 1'b0;
    if (issue_valid) begin
      if (issue_use_rs1 && w_eff_busy[raddr1])            stall_o = 1'b1;
      if (issue_use_rs2 && w_eff_busy[raddr2])            stall_o = 1'b1;
      if (issue_we && w_rd_nz && w_eff_busy[issue_rd])    stall_o = 1'b1;
    end
  end

  // New producer marks its destination busy; applied after the clear so set wins.
  always_comb begin
    w_set_mask = '0;
    if (issue_valid && !stall_o && issue_we && w_rd_nz) w_set_mask[issue_rd] = 1'b1;
  end

  assign w_busy_nxt = (r_busy & ~w_wb_mask) | w_set_mask;

  // Operand reads: x0 is hard zero, otherwise bypass a matching write-back.
  assign rdata1 = (raddr1 == '0) ? '0 :
                  (w_wb && (waddr == raddr1)) ? wdata : r_regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (w_wb && (waddr == raddr2)) ? wdata : r_regs[raddr2];

  // Debug and halt reporting observe stored state only.
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
  assign a0_o     = r_regs[10];
  assign wr_cnt_o = r_wr_cnt;

  // Register storage; x0 stays zero because it is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Busy scoreboard and write-event counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (we) r_wr_cnt <= r_wr_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a driver applies directed and random cycles
// and queues the expected outputs from a behavioural model; a monitor pops
// and compares once per cycle on the falling edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr, issue_rd, dbg_addr;
  logic [63:0] rdata1, rdata2, wdata, dbg_data, a0_o, wr_cnt_o;
  logic        we, issue_valid, issue_use_rs1, issue_use_rs2, issue_we, stall_o;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(64), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_we(issue_we), .issue_rd(issue_rd),
    .stall_o(stall_o), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .a0_o(a0_o), .wr_cnt_o(wr_cnt_o)
  );

  typedef struct packed {
    logic        rst_n;
    logic [4:0]  ra1, ra2;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        iv, u1, u2, iwe;
    logic [4:0]  ird, da;
  } st_t;

  typedef struct packed {
    logic        chk;
    logic [63:0] r1, r2, dbg, a0, cnt;
    logic        stall;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Architectural model: plain arrays updated from the rules.
  logic [63:0] m_reg [32];
  bit          m_busy[32];
  logic [63:0] m_cnt;
  st_t         applied;

  function automatic st_t idle();
    st_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_read(st_t s, logic [4:0] a);
    if (a == 0) return 64'd0;
    if (s.we && s.wa == a) return s.wd;
    return m_reg[a];
  endfunction

  function automatic bit m_eff_busy(st_t s, logic [4:0] r);
    return m_busy[r] && !(s.we && s.wa == r);
  endfunction

  function automatic bit m_stall(st_t s);
    if (!s.iv) return 1'b0;
    return (s.u1 && m_eff_busy(s, s.ra1)) || (s.u2 && m_eff_busy(s, s.ra2)) ||
           (s.iwe && s.ird != 0 && m_eff_busy(s, s.ird));
  endfunction

  task automatic model_edge(st_t s);
    bit stl;
    if (!s.rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 64'd0;
    end else begin
      stl = m_stall(s);
      if (s.we) m_cnt = m_cnt + 64'd1;
      if (s.we && s.wa != 0) begin
        m_reg[s.wa]  = s.wd;
        m_busy[s.wa] = 1'b0;
      end
      if (s.iv && !stl && s.iwe && s.ird != 0) m_busy[s.ird] = 1'b1;
    end
  endtask

  task automatic drive(st_t s);
    rst_n = s.rst_n; raddr1 = s.ra1; raddr2 = s.ra2;
    we = s.we; waddr = s.wa; wdata = s.wd;
    issue_valid = s.iv; issue_use_rs1 = s.u1; issue_use_rs2 = s.u2;
    issue_we = s.iwe; issue_rd = s.ird; dbg_addr = s.da;
  endtask

  // One clock: retire the applied cycle into the model, apply the next one.
  task automatic step(st_t s);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge(applied);
    applied = s;
    drive(s);
    e.chk   = s.rst_n;
    e.r1    = m_read(s, s.ra1);
    e.r2    = m_read(s, s.ra2);
    e.dbg   = (s.da == 0) ? 64'd0 : m_reg[s.da];
    e.a0    = m_reg[10];
    e.cnt   = m_cnt;
    e.stall = m_stall(s);
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          chk("rdata1", rdata1, e.r1);
          chk("rdata2", rdata2, e.r2);
          chk("stall_o", {63'd0, stall_o}, {63'd0, e.stall});
          chk("dbg_data", dbg_data, e.dbg);
          chk("a0_o", a0_o, e.a0);
          chk("wr_cnt_o", wr_cnt_o, e.cnt);
        end
      end
    end
  end

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t s;
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 64'hDEAD; m_busy[i] = 1'b0;
    end
    m_cnt = 64'hDEAD;
    applied = idle();
    applied.rst_n = 1'b0;
    drive(applied);

    // Reset held two cycles, then read.
    s = idle(); s.rst_n = 1'b0; step(s); step(s);
    s = idle(); s.ra1 = 5; s.ra2 = 31; step(s);

    // Write with same-cycle bypass, then stored value.
    s = idle(); s.we = 1; s.wa = 7; s.wd = 64'h1234_5678_9ABC_DEF0; s.ra1 = 7; s.da = 7; step(s);
    s = idle(); s.ra1 = 7; s.da = 7; step(s);

    // x0 protection.
    s = idle(); s.we = 1; s.wa = 0; s.wd = '1; s.ra1 = 0; s.da = 0; step(s);
    s = idle(); s.ra1 = 0; step(s);

    // RAW interlock on x3.
    s = idle(); s.iv = 1; s.iwe = 1; s.ird = 3; step(s);
    s = idle(); s.iv = 1; s.u1 = 1; s.ra1 = 3; step(s);
    s.we = 1; s.wa = 3; s.wd = 64'h42; step(s);
    s = idle(); s.iv = 1; s.u1 = 1; s.ra1 = 3; step(s);

    // Set/clear collision on x4, then WAW.
    s = idle(); s.iv = 1; s.iwe = 1; s.ird = 4; step(s);
    s = idle(); s.we = 1; s.wa = 4; s.wd = 64'h4; s.iv = 1; s.iwe = 1; s.ird = 4; step(s);
    s = idle(); s.iv = 1; s.iwe = 1; s.ird = 4; s.da = 4; step(s);

    // Reset mid-operation with a write presented during reset.
    s = idle(); s.we = 1; s.wa = 10; s.wd = 64'h55; s.iv = 1; s.iwe = 1; s.ird = 9; step(s);
    s = idle(); s.ra1 = 9; s.iv = 1; s.u1 = 1; step(s);
    s = idle(); s.rst_n = 1'b0; s.we = 1; s.wa = 10; s.wd = 64'h77; step(s);
    s = idle(); s.iv = 1; s.u1 = 1; s.ra1 = 9; s.da = 10; step(s);

    // Randomized traffic concentrated on a few registers.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.ra1 = pick_addr(); s.ra2 = pick_addr();
      s.we  = ($urandom_range(0, 2) == 0);
      s.wa  = pick_addr();
      s.wd  = {$urandom, $urandom};
      s.iv  = $urandom_range(0, 1); s.u1 = $urandom_range(0, 1);
      s.u2  = $urandom_range(0, 1); s.iwe = $urandom_range(0, 1);
      s.ird = pick_addr(); s.da = pick_addr();
      step(s);
    end

    s = idle(); step(s);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
